// File: rtl/i2c_pkg.sv
// i2c_pkg: command encoding, FSM states and per-phase drive table for the
// bit-level I2C master.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    localparam int I2C_PHASES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2c_state_e;

    // Open-drain enables {scl_oe, sda_oe} for a command in a given phase.
    // 1 pulls the line low, 0 releases it.
    function automatic logic [1:0] i2c_drive(input logic [1:0] cmd,
                                             input logic       din,
                                             input logic [1:0] phase);
        logic scl_oe;
        logic sda_oe;
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (cmd)
            I2C_CMD_START: begin
                scl_oe = (phase == 2'd3);
                sda_oe = phase[1];
            end
            I2C_CMD_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase != 2'd3);
            end
            I2C_CMD_WRITE: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = ~din;
            end
            default: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = 1'b0;
            end
        endcase
        return {scl_oe, sda_oe};
    endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// i2c_qtr_timer: quarter-bit down-counter. Loads QUARTER-1, counts to zero
// and flags tick there; hold freezes the count and masks tick (clock stretch).
module i2c_qtr_timer #(
    parameter logic [15:0] QUARTER = 16'd250
) (
    input  logic clk,
    input  logic n_rst,
    input  logic load,
    input  logic hold,
    output logic tick
);

    logic [15:0] cnt_q;

    // Down-counter: load has priority, then hold, then decrement to zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt_q <= 16'd0;
        else if (load)
            cnt_q <= QUARTER - 16'd1;
        else if (!hold && cnt_q != 16'd0)
            cnt_q <= cnt_q - 16'd1;
    end

    assign tick = (cnt_q == 16'd0) && !hold;

endmodule

// File: rtl/i2c_bit_master.sv
// i2c_bit_master: bit-level I2C master engine. One START/STOP/WRITE/READ
// primitive per handshake, four quarter-bit phases each, open-drain drive.
// Optional feature macro: I2C_CLK_STRETCH_EN (slave clock stretching on the
// phase where SCL is released after being held low).
module i2c_bit_master
    import i2c_pkg::*;
#(
    parameter logic [15:0] QUARTER = 16'd250
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       din,
    output logic       done,
    output logic       dout,
    output logic       arb_lost,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    i2c_state_e state_q, state_d;
    logic [1:0] phase_q;
    logic [1:0] cmd_q;
    logic       din_q;
    logic       samp_q;
    logic       dout_q;
    logic       tick;
    logic       tick_run;
    logic       hold;
    logic       accept;

    assign tick_run = (state_q == ST_RUN) && tick;
    assign accept   = cmd_valid && cmd_ready;

    i2c_qtr_timer #(.QUARTER(QUARTER)) u_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (accept || (tick_run && phase_q != 2'd3)),
        .hold  (hold),
        .tick  (tick)
    );

`ifdef I2C_CLK_STRETCH_EN
    logic arm_q;

    // Arm the stretch check on entry to P1 (SCL just released) for every
    // command except START; disarm once the bus shows SCL high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            arm_q <= 1'b0;
        else if (accept)
            arm_q <= 1'b0;
        else if (tick_run && phase_q == 2'd0)
            arm_q <= (cmd_q != I2C_CMD_START);
        else if (scl_in)
            arm_q <= 1'b0;
    end

    assign hold = (state_q == ST_RUN) && arm_q && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus done/arb_lost/cmd_ready; a finishing command frees the
    // engine in its done cycle so the next one can start with no gap.
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        arb_lost  = 1'b0;
        cmd_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick && phase_q == 2'd2 && cmd_q == I2C_CMD_WRITE &&
                    din_q && !sda_in) begin
                    done     = 1'b1;
                    arb_lost = 1'b1;
                end
                if (tick && phase_q == 2'd3)
                    done = 1'b1;
                if (done) begin
                    cmd_ready = 1'b1;
                    state_d   = cmd_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture, phase sequencing and registered open-drain drive.
    // Outputs only change on accept, phase advance or arbitration loss, so
    // IDLE keeps the last command's final levels.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q <= 2'd0;
            cmd_q   <= I2C_CMD_START;
            din_q   <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else if (accept) begin
            phase_q          <= 2'd0;
            cmd_q            <= cmd;
            din_q            <= din;
            {scl_oe, sda_oe} <= i2c_drive(cmd, din, 2'd0);
        end else if (arb_lost) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else if (tick_run && phase_q != 2'd3) begin
            phase_q          <= phase_q + 2'd1;
            {scl_oe, sda_oe} <= i2c_drive(cmd_q, din_q, phase_q + 2'd1);
        end
    end

    // SDA sample at the end of P2 (SCL high); READ publishes it on done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            samp_q <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            if (tick_run && phase_q == 2'd2)
                samp_q <= sda_in;
            if (done && cmd_q == I2C_CMD_READ)
                dout_q <= samp_q;
        end
    end

    assign dout = (done && cmd_q == I2C_CMD_READ) ? samp_q : dout_q;

endmodule
